// File: rtl/syn_down.sv
// Synchronous down counter with parallel load, one-shot / auto-reload
// terminal behaviour and a registered single-cycle borrow pulse.
module syn_down #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             zero,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q      <= '0;
            reload <= '0;
            borrow <= 1'b0;
            state  <= IDLE;
        end else begin
            borrow <= 1'b0;
            if (load) begin
                q      <= din;
                reload <= din;
                state  <= RUN;
            end else begin
                unique case (state)
                    RUN: begin
                        if (en) begin
                            if (q != '0) begin
                                q <= q - 1'b1;
                            end else begin
                                // terminal edge replaces the decrement
                                borrow <= 1'b1;
                                if (mode) q     <= reload;
                                else      state <= DONE;
                            end
                        end
                    end
                    IDLE, DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign qbar = ~q;
    assign zero = (q == '0);
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_syn_down.sv
// Self-checking bench for syn_down: directed scenarios plus randomized
// traffic compared against a behavioural model of the counter.
module tb_syn_down;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         clr_n = 1'b0;
    logic         en    = 1'b0;
    logic         load  = 1'b0;
    logic         mode  = 1'b0;
    logic [W-1:0] din   = '0;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         zero;
    logic         borrow;
    logic         busy;
    logic         done;

    int npass = 0;
    int ntot  = 0;

    // behavioural model: count value, stored reload, pulse, running, finished
    int unsigned m_q;
    int unsigned m_rl;
    bit          m_b;
    bit          m_run;
    bit          m_fin;

    syn_down #(.WIDTH(W)) dut (
        .clk(clk), .clr_n(clr_n), .en(en), .load(load), .din(din),
        .mode(mode), .q(q), .qbar(qbar), .zero(zero), .borrow(borrow),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q = 0; m_rl = 0; m_b = 0; m_run = 0; m_fin = 0;
    endtask

    // one rising edge; model follows the counting rules, then sample at +1
    task automatic tick();
        @(posedge clk);
        m_b = 0;
        if (load) begin
            m_q = din; m_rl = din; m_run = 1; m_fin = 0;
        end else if (m_run && en) begin
            if (m_q > 0) begin
                m_q = m_q - 1;
            end else begin
                m_b = 1;
                if (mode) m_q = m_rl;
                else begin m_run = 0; m_fin = 1; end
            end
        end
        #1;
    endtask

    task automatic start(input int v, input bit md);
        mode = md; din = W'(v); load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b1;
        start(7, 0);
        #2 clr_n = 1'b0;
        model_reset();
        #1;
        ntot++; if (q !== 4'd0) $display("FAIL reset_q: got %0d want 0", q); else npass++;
        ntot++; if (qbar !== 4'hF) $display("FAIL reset_qbar: got %h want f", qbar); else npass++;
        ntot++; if (zero !== 1'b1) $display("FAIL reset_zero: got %b want 1", zero); else npass++;
        ntot++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else npass++;
        ntot++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else npass++;
        ntot++; if (borrow !== 1'b0) $display("FAIL reset_borrow: got %b want 0", borrow); else npass++;
        clr_n = 1'b1;
        en = 1'b1;
        tick();
        ntot++; if (busy !== 1'b0 || q !== 4'd0) $display("FAIL reset_idle: busy=%b q=%0d want 0 0", busy, q); else npass++;
        en = 1'b0;
    endtask

    task automatic test_oneshot();
        int exp_q[4] = '{3, 2, 1, 0};
        start(3, 0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            ntot++; if (q !== W'(exp_q[i]) || borrow !== 1'b0 || busy !== 1'b1)
                $display("FAIL oneshot_seq%0d: q=%0d b=%b busy=%b want %0d 0 1", i, q, borrow, busy, exp_q[i]);
            else npass++;
        end
        tick();
        ntot++; if (borrow !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || q !== 4'd0)
            $display("FAIL oneshot_term: b=%b done=%b busy=%b q=%0d want 1 1 0 0", borrow, done, busy, q);
        else npass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            ntot++; if (q !== 4'd0 || borrow !== 1'b0 || done !== 1'b1)
                $display("FAIL oneshot_hold%0d: q=%0d b=%b done=%b want 0 0 1", i, q, borrow, done);
            else npass++;
        end
        en = 1'b0;
    endtask

    task automatic test_autoreload();
        int exp_q[7] = '{2, 1, 0, 2, 1, 0, 2};
        bit exp_b[7] = '{0, 0, 0, 1, 0, 0, 1};
        start(2, 1);
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            ntot++; if (q !== W'(exp_q[i]) || borrow !== exp_b[i] || busy !== 1'b1)
                $display("FAIL reload_seq%0d: q=%0d b=%b busy=%b want %0d %b 1", i, q, borrow, busy, exp_q[i], exp_b[i]);
            else npass++;
        end
        en = 1'b0;
    endtask

    task automatic test_enable();
        bit en_seq[6] = '{1, 0, 0, 1, 0, 1};
        int exp_q[6]  = '{4, 4, 4, 3, 3, 2};
        start(5, 0);
        for (int i = 0; i < 6; i++) begin
            en = en_seq[i];
            tick();
            ntot++; if (q !== W'(exp_q[i]) || borrow !== 1'b0)
                $display("FAIL enable_seq%0d: q=%0d b=%b want %0d 0", i, q, borrow, exp_q[i]);
            else npass++;
        end
        en = 1'b0;
    endtask

    task automatic test_load_priority();
        int exp_q[3] = '{9, 8, 7};
        start(7, 0);
        en = 1'b1;
        tick();
        tick();
        ntot++; if (q !== 4'd5) $display("FAIL prio_setup: q=%0d want 5", q); else npass++;
        din = 4'd9; load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            load = 1'b0;
            ntot++; if (q !== W'(exp_q[i]))
                $display("FAIL prio_seq%0d: q=%0d want %0d", i, q, exp_q[i]);
            else npass++;
        end
        en = 1'b0;
    endtask

    task automatic test_midreset();
        start(8, 0);
        en = 1'b1;
        tick();
        tick();
        ntot++; if (q !== 4'd6) $display("FAIL midrst_setup: q=%0d want 6", q); else npass++;
        #1 clr_n = 1'b0;
        model_reset();
        #1;
        ntot++; if (q !== 4'd0 || busy !== 1'b0)
            $display("FAIL midrst_now: q=%0d busy=%b want 0 0", q, busy);
        else npass++;
        #2 clr_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            ntot++; if (q !== 4'd0 || busy !== 1'b0 || borrow !== 1'b0)
                $display("FAIL midrst_idle%0d: q=%0d busy=%b b=%b want 0 0 0", i, q, busy, borrow);
            else npass++;
        end
        en = 1'b0;
    endtask

    task automatic test_zero_load();
        start(0, 0);
        en = 1'b1;
        tick();
        ntot++; if (borrow !== 1'b1 || done !== 1'b1)
            $display("FAIL zero_oneshot: b=%b done=%b want 1 1", borrow, done);
        else npass++;
        en = 1'b0;
        start(0, 1);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            ntot++; if (borrow !== 1'b1 || q !== 4'd0 || busy !== 1'b1)
                $display("FAIL zero_reload%0d: b=%b q=%0d busy=%b want 1 0 1", i, borrow, q, busy);
            else npass++;
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            load = ($urandom_range(0, 9) == 0);
            en   = ($urandom_range(0, 3) != 0);
            din  = W'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) mode = $urandom_range(0, 1);
            if ($urandom_range(0, 79) == 0) begin
                clr_n = 1'b0;
                model_reset();
                #2 clr_n = 1'b1;
            end
            tick();
            ntot++; if (q !== W'(m_q) || borrow !== m_b || busy !== m_run || done !== m_fin
                        || qbar !== ~W'(m_q) || zero !== (m_q == 0))
                $display("FAIL random%0d: q=%0d b=%b busy=%b done=%b want %0d %b %b %b",
                         i, q, borrow, busy, done, m_q, m_b, m_run, m_fin);
            else npass++;
        end
        load = 1'b0;
        en   = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_enable();
        test_load_priority();
        test_midreset();
        test_zero_load();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/syn_down.md
SYN_DOWN -- requirements
Module: syn_down

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port clr_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port en  input  1  count enable; the counter decrements only on edges where en=1.
REQ-005 SHALL have port load  input  1  synchronous parallel load of din; starts a count.
REQ-006 SHALL have port din  input  WIDTH  load and reload value.
REQ-007 SHALL have port mode  input  1  terminal behaviour: 0 = one-shot, 1 = auto-reload.
REQ-008 SHALL have port q  output  WIDTH  current count, registered.
REQ-009 SHALL have port qbar  output  WIDTH  bitwise complement of q, combinational.
REQ-010 SHALL have port zero  output  1  combinational, 1 when q == 0.
REQ-011 SHALL have port borrow  output  1  registered single-cycle terminal-count pulse.
REQ-012 SHALL have port busy  output  1  1 while the FSM is in RUN.
REQ-013 SHALL have port done  output  1  1 while the FSM is in DONE.

Function
REQ-014 SHALL implement a fully synchronous down counter; every flop is clocked by clk, with no ripple clocking.
REQ-015 SHALL hold an internal reload register, WIDTH bits, written only by load.
REQ-016 SHALL implement FSM states IDLE, RUN and DONE: busy = (RUN), done = (DONE).
REQ-017 load=1 in any state SHALL, on the edge: q <= din, reload <= din, state <= RUN, borrow <= 0.
REQ-018 load SHALL take priority over en; the load edge never decrements.
REQ-019 In RUN with en=1 and q != 0, each edge SHALL do q <= q - 1, borrow <= 0, state unchanged.
REQ-020 In RUN with en=1, q == 0 and mode=1, the edge SHALL do q <= reload, borrow <= 1, and remain in RUN.
REQ-021 In RUN with en=1, q == 0 and mode=0, the edge SHALL do q stays 0, borrow <= 1, state <= DONE.
REQ-022 mode SHALL be sampled only on the terminal (q == 0) edge; changing it mid-count has no other effect.
REQ-023 In RUN with en=0, the edge SHALL hold q and state, with borrow <= 0.
REQ-024 In IDLE and DONE, en SHALL be ignored: q holds and borrow <= 0; only load leaves these states.
REQ-025 borrow SHALL be high for exactly one cycle per terminal event and never high on two consecutive cycles unless successive enabled terminal edges occur (reload value 0, mode=1).
REQ-026 A count from load value N with en held high SHALL produce borrow after exactly N+1 enabled edges following the load edge.
REQ-027 din = 0 SHALL be legal:
- mode=0: the next enabled edge gives borrow and DONE.
- mode=1: borrow pulses on every enabled edge while q stays 0.
REQ-028 Arithmetic SHALL be unsigned modulo 2^WIDTH; q SHALL never go below 0 (the terminal edge replaces the decrement).

Reset
REQ-029 clr_n=0 SHALL immediately, without waiting for clk, force q=0, reload=0, borrow=0 and state=IDLE, so that qbar is all ones, zero=1, busy=0 and done=0.
REQ-030 Reset asserted mid-count SHALL abort the count; after release the block stays in IDLE until load.
REQ-031 The first rising edge after clr_n deasserts SHALL be a normal functional edge.

Verification
REQ-032 Reset check: clr_n=0 between edges -> q=0000, qbar=1111, zero=1, busy=0, done=0, borrow=0 with no clock edge.
REQ-033 One-shot check: mode=0, load din=3, then en=1 held.
- q SHALL read 3,2,1,0 on successive edges.
- borrow=1 for one cycle after the 4th enabled edge, then done=1, busy=0.
- q SHALL stay 0 for 5 more edges.
REQ-034 Auto-reload check: mode=1, load din=2, en=1 held.
- q SHALL read 2,1,0,2,1,0,2.
- borrow SHALL pulse once per reload, i.e. every 3 edges.
- busy SHALL stay 1 throughout.
REQ-035 Enable gating check: load din=5 and toggle en 1,0,0,1,0,1 -> q SHALL read 4,4,4,3,3,2, with borrow=0 throughout.
REQ-036 Load-priority check: at q=5 in RUN, assert load=1, din=9 with en=1 -> q=9 on the next edge (not 8); the count then continues 8,7,...
REQ-037 Mid-count reset check: with q=6 in RUN, pulse clr_n low for 3 time units between edges -> q=0 and busy=0 immediately; en=1 after release leaves q=0 in IDLE until load.
